// File: rtl/s27_resp_misr.sv
// Single-input MISR response compactor for the s27 G17 output: folds LEN samples
// into a signature and flags PASS against EXP_SIG. Optional ONES counter: S27_RESP_ONES_EN.
module s27_resp_misr #(
  parameter int                 SIG_W = 16,
  parameter int                 CNT_W = 16,
  parameter logic [SIG_W-1:0]   POLY  = 16'h1021,
  parameter logic [SIG_W-1:0]   SEED  = 16'hFFFF
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] LEN,
  input  logic             G17,
  input  logic [SIG_W-1:0] EXP_SIG,
  output logic             BUSY,
  output logic             DONE,
  output logic [SIG_W-1:0] SIG,
  output logic             PASS,
  output logic [CNT_W-1:0] ONES
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_REPORT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_rem;
  logic [SIG_W-1:0] r_sig;
  logic             r_pass;
  logic [SIG_W-1:0] w_sig_nxt;
  logic             w_start_ok;
  logic             w_capture;
  logic             w_last;

  assign w_start_ok = (r_state == S_IDLE) && START;
  assign w_capture  = (r_state == S_CAPTURE);
  assign w_last     = w_capture && (r_rem == CNT_W'(1));

  // Shift left, fold the polynomial in when the MSB falls out, inject G17 at bit 0.
  assign w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0}
                   ^ (r_sig[SIG_W-1] ? POLY : '0)
                   ^ {{(SIG_W-1){1'b0}}, G17};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (START) w_state_nxt = (LEN == '0) ? S_REPORT : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (w_last) w_state_nxt = S_REPORT;
      end
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      r_rem  <= '0;
      r_sig  <= SEED;
      r_pass <= 1'b0;
    end else if (w_start_ok) begin
      r_rem  <= LEN;
      r_sig  <= SEED;
      // An empty window reports immediately, so its verdict is the seed itself.
      r_pass <= (LEN == '0) && (SEED == EXP_SIG);
    end else if (w_capture) begin
      r_rem <= r_rem - CNT_W'(1);
      r_sig <= w_sig_nxt;
      if (w_last) r_pass <= (w_sig_nxt == EXP_SIG);
    end
  end

`ifdef S27_RESP_ONES_EN
  logic [CNT_W-1:0] r_ones;

  always_ff @(posedge CK) begin
    if (RST)                  r_ones <= '0;
    else if (w_start_ok)      r_ones <= '0;
    else if (w_capture && G17) r_ones <= r_ones + CNT_W'(1);
  end

  assign ONES = r_ones;
`else
  assign ONES = '0;
`endif

  assign BUSY = (r_state == S_CAPTURE);
  assign DONE = (r_state == S_REPORT);
  assign SIG  = r_sig;
  assign PASS = r_pass;

endmodule

// File: tb/tb_s27_resp_misr.sv
// Directed self-checking bench for s27_resp_misr; ONES expectations follow S27_RESP_ONES_EN.
module tb_s27_resp_misr;

  logic        CK;
  logic        RST;
  logic        START;
  logic [15:0] LEN;
  logic        G17;
  logic [15:0] EXP_SIG;
  logic        BUSY;
  logic        DONE;
  logic [15:0] SIG;
  logic        PASS;
  logic [15:0] ONES;

  int n_checks = 0;
  int n_fail   = 0;

  s27_resp_misr dut (
    .CK      (CK),
    .RST     (RST),
    .START   (START),
    .LEN     (LEN),
    .G17     (G17),
    .EXP_SIG (EXP_SIG),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .SIG     (SIG),
    .PASS    (PASS),
    .ONES    (ONES)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic g);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, g};
  endfunction

  function automatic logic [15:0] ones_exp(input int n);
`ifdef S27_RESP_ONES_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  logic [15:0] exp_sig;
  logic [9:0]  pat10;
  int          done_cnt;
  int          n_ones;

  initial begin
    RST = 1'b1; START = 1'b0; LEN = '0; G17 = 1'b0; EXP_SIG = '0;

    // Reset held for two edges.
    repeat (2) @(negedge CK);
    check("rst_sig",  32'(SIG),  32'h0000FFFF);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_pass", 32'(PASS), 32'd0);
    check("rst_ones", 32'(ONES), 32'd0);
    RST = 1'b0;
    @(negedge CK);

    // LEN=0: immediate report, seed compared against EXP_SIG.
    LEN = 16'd0; EXP_SIG = 16'hFFFF; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    check("len0_busy", 32'(BUSY), 32'd0);
    check("len0_done", 32'(DONE), 32'd1);
    check("len0_sig",  32'(SIG),  32'h0000FFFF);
    check("len0_pass", 32'(PASS), 32'd1);
    @(negedge CK);
    check("len0_done_drop", 32'(DONE), 32'd0);

    // LEN=1, G17=0 -> EFDF.
    LEN = 16'd1; EXP_SIG = 16'hEFDF; G17 = 1'b0; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    check("len1a_busy",    32'(BUSY), 32'd1);
    check("len1a_done_lo", 32'(DONE), 32'd0);
    check("len1a_pass_clr", 32'(PASS), 32'd0);
    @(negedge CK);
    check("len1a_done", 32'(DONE), 32'd1);
    check("len1a_busy_lo", 32'(BUSY), 32'd0);
    check("len1a_sig",  32'(SIG),  32'h0000EFDF);
    check("len1a_pass", 32'(PASS), 32'd1);
    @(negedge CK);

    // LEN=1, G17=1 -> EFDE, mismatch.
    LEN = 16'd1; EXP_SIG = 16'hEFDF; G17 = 1'b1; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    check("len1b_pass_clr", 32'(PASS), 32'd0);
    @(negedge CK);
    check("len1b_done", 32'(DONE), 32'd1);
    check("len1b_sig",  32'(SIG),  32'h0000EFDE);
    check("len1b_pass", 32'(PASS), 32'd0);
    check("len1b_ones", 32'(ONES), 32'(ones_exp(1)));
    @(negedge CK);

    // LEN=8 alternating G17, START re-pulsed and LEN changed mid-window.
    LEN = 16'd8; EXP_SIG = 16'h0000; START = 1'b1;
    @(negedge CK);
    START = 1'b0; LEN = 16'd3;
    exp_sig = 16'hFFFF; done_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      G17 = k[0];
      START = (k == 4);
      exp_sig = misr(exp_sig, G17);
      if (k == 8) EXP_SIG = exp_sig;
      if (DONE) done_cnt++;
      check($sformatf("len8_busy_%0d", k), 32'(BUSY), 32'd1);
      @(negedge CK);
    end
    START = 1'b0;
    check("len8_done", 32'(DONE), 32'd1);
    check("len8_sig",  32'(SIG),  32'(exp_sig));
    check("len8_pass", 32'(PASS), 32'd1);
    check("len8_ones", 32'(ONES), 32'(ones_exp(4)));
    check("len8_early_done", 32'(done_cnt), 32'd0);
    @(negedge CK);
    check("len8_done_drop", 32'(DONE), 32'd0);
    @(negedge CK);
    check("len8_no_rerun_busy", 32'(BUSY), 32'd0);
    check("len8_no_rerun_done", 32'(DONE), 32'd0);

    // LEN=10 aborted by reset on the 5th capture edge.
    LEN = 16'd10; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      G17 = 1'b1;
      if (k == 5) RST = 1'b1;
      @(negedge CK);
    end
    RST = 1'b0;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_sig",  32'(SIG),  32'h0000FFFF);
    check("abort_ones", 32'(ONES), 32'd0);
    check("abort_pass", 32'(PASS), 32'd0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge CK);
      if (DONE) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);

    // Full 10-sample window after the abort; EXP_SIG only matters on the last sample.
    pat10 = 10'b1101001110;
    LEN = 16'd10; EXP_SIG = 16'h0000; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    exp_sig = 16'hFFFF; n_ones = 0; done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      G17 = pat10[9-k];
      if (G17) n_ones++;
      exp_sig = misr(exp_sig, G17);
      EXP_SIG = (k == 9) ? exp_sig : ~exp_sig;
      if (DONE) done_cnt++;
      @(negedge CK);
    end
    check("len10_early_done", 32'(done_cnt), 32'd0);
    check("len10_done", 32'(DONE), 32'd1);
    check("len10_sig",  32'(SIG),  32'(exp_sig));
    check("len10_pass", 32'(PASS), 32'd1);
    check("len10_ones", 32'(ONES), 32'(ones_exp(n_ones)));
    @(negedge CK);
    check("len10_hold_sig",  32'(SIG),  32'(exp_sig));
    check("len10_hold_pass", 32'(PASS), 32'd1);

    // Back-to-back START in the cycle right after DONE.
    LEN = 16'd2; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    check("b2b_busy",     32'(BUSY), 32'd1);
    check("b2b_reseed",   32'(SIG),  32'h0000FFFF);
    check("b2b_pass_clr", 32'(PASS), 32'd0);
    check("b2b_ones_clr", 32'(ONES), 32'd0);
    exp_sig = misr(misr(16'hFFFF, 1'b1), 1'b1);
    G17 = 1'b1; EXP_SIG = exp_sig ^ 16'h0001;
    @(negedge CK);
    check("b2b_mid_pass", 32'(PASS), 32'd0);
    // Bounded wait for the report pulse.
    done_cnt = 0;
    for (int c = 0; c < 5 && !DONE; c++) begin
      @(negedge CK);
      done_cnt++;
    end
    check("b2b_done_lat", 32'(done_cnt), 32'd1);
    check("b2b_sig",  32'(SIG),  32'(exp_sig));
    check("b2b_pass", 32'(PASS), 32'd0);
    check("b2b_ones", 32'(ONES), 32'(ones_exp(2)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
